// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for viterbi_decoder: clear, feed FRAME_LEN pairs, flush TBLEN zero pairs, collect FRAME_LEN bits.
// All outputs registered (1 cycle); s_ready only in FEED, m_* has no backpressure; VITERBI_CTRL_STATS_EN adds stat counters.
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN = 512,
    parameter int TBLEN     = 32,
    parameter int CLR_CYC   = 2,
    parameter int TIMEOUT   = 4095
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        start,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [1:0]  s_data,
    output logic        dec_RSTn,
    output logic        dec_in_valid,
    output logic [1:0]  dec_in,
    input  logic        dec_out_valid,
    input  logic        dec_out,
    output logic        m_valid,
    output logic        m_data,
    output logic        m_last,
    output logic        busy,
    output logic        done,
`ifdef VITERBI_CTRL_STATS_EN
    output logic        err_timeout,
    output logic [15:0] stat_frames,
    output logic [15:0] stat_timeouts
`else
    output logic        err_timeout
`endif
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int FL_W  = $clog2(TBLEN + 1);
    localparam int CLR_W = $clog2(CLR_CYC + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [FL_W-1:0]    fl_cnt_q, fl_cnt_d;
    logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [TO_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic               err_q, err_d;
    logic               s_ready_q, s_ready_d;
    logic               dec_rstn_q, dec_rstn_d;
    logic               dec_in_valid_q, dec_in_valid_d;
    logic [1:0]         dec_in_q, dec_in_d;
    logic               m_valid_q, m_valid_d;
    logic               m_data_q, m_data_d;
    logic               m_last_q, m_last_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;
`ifdef VITERBI_CTRL_STATS_EN
    logic [15:0]        stat_frames_q, stat_frames_d;
    logic [15:0]        stat_timeouts_q, stat_timeouts_d;
`endif

    always_comb begin
        state_d        = state_q;
        in_cnt_d       = in_cnt_q;
        out_cnt_d      = out_cnt_q;
        fl_cnt_d       = fl_cnt_q;
        clr_cnt_d      = clr_cnt_q;
        idle_cnt_d     = idle_cnt_q;
        err_d          = err_q;
        dec_in_valid_d = 1'b0;
        dec_in_d       = 2'b00;
        m_valid_d      = 1'b0;
        m_data_d       = 1'b0;
        m_last_d       = 1'b0;
        accept         = (state_q == S_FEED) && s_valid && s_ready_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CLEAR;
                    err_d      = 1'b0;
                    in_cnt_d   = '0;
                    out_cnt_d  = '0;
                    fl_cnt_d   = '0;
                    clr_cnt_d  = '0;
                    idle_cnt_d = '0;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == CLR_W'(CLR_CYC - 1)) state_d = S_FEED;
                else                                   clr_cnt_d = clr_cnt_q + 1'b1;
            end
            S_FEED: begin
                if (accept) begin
                    dec_in_valid_d = 1'b1;
                    dec_in_d       = s_data;
                    in_cnt_d       = in_cnt_q + 1'b1;
                    if (in_cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                dec_in_valid_d = 1'b1;
                if (fl_cnt_q == FL_W'(TBLEN - 1)) state_d = S_DRAIN;
                else                               fl_cnt_d = fl_cnt_q + 1'b1;
            end
            S_DRAIN: begin
                // Completion wins over the idle watchdog.
                if (out_cnt_q == CNT_W'(FRAME_LEN)) begin
                    state_d = S_DONE;
                end else if (dec_out_valid) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if ((state_q == S_FEED || state_q == S_FLUSH || state_q == S_DRAIN) &&
            dec_out_valid && (out_cnt_q != CNT_W'(FRAME_LEN))) begin
            m_valid_d = 1'b1;
            m_data_d  = dec_out;
            m_last_d  = (out_cnt_q == CNT_W'(FRAME_LEN - 1));
            out_cnt_d = out_cnt_q + 1'b1;
        end

        // Status outputs follow the next state so they line up with it.
        s_ready_d  = (state_d == S_FEED);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        dec_rstn_d = (state_d != S_IDLE) && (state_d != S_CLEAR);

`ifdef VITERBI_CTRL_STATS_EN
        stat_frames_d   = stat_frames_q;
        stat_timeouts_d = stat_timeouts_q;
        if (state_q != S_DONE && state_d == S_DONE) begin
            if (stat_frames_q != 16'hFFFF) stat_frames_d = stat_frames_q + 16'd1;
            if (err_d && !err_q && stat_timeouts_q != 16'hFFFF)
                stat_timeouts_d = stat_timeouts_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q        <= S_IDLE;
            in_cnt_q       <= '0;
            out_cnt_q      <= '0;
            fl_cnt_q       <= '0;
            clr_cnt_q      <= '0;
            idle_cnt_q     <= '0;
            err_q          <= 1'b0;
            s_ready_q      <= 1'b0;
            dec_rstn_q     <= 1'b0;
            dec_in_valid_q <= 1'b0;
            dec_in_q       <= 2'b00;
            m_valid_q      <= 1'b0;
            m_data_q       <= 1'b0;
            m_last_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef VITERBI_CTRL_STATS_EN
            stat_frames_q   <= '0;
            stat_timeouts_q <= '0;
`endif
        end else begin
            state_q        <= state_d;
            in_cnt_q       <= in_cnt_d;
            out_cnt_q      <= out_cnt_d;
            fl_cnt_q       <= fl_cnt_d;
            clr_cnt_q      <= clr_cnt_d;
            idle_cnt_q     <= idle_cnt_d;
            err_q          <= err_d;
            s_ready_q      <= s_ready_d;
            dec_rstn_q     <= dec_rstn_d;
            dec_in_valid_q <= dec_in_valid_d;
            dec_in_q       <= dec_in_d;
            m_valid_q      <= m_valid_d;
            m_data_q       <= m_data_d;
            m_last_q       <= m_last_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
`ifdef VITERBI_CTRL_STATS_EN
            stat_frames_q   <= stat_frames_d;
            stat_timeouts_q <= stat_timeouts_d;
`endif
        end
    end

    assign s_ready      = s_ready_q;
    assign dec_RSTn     = dec_rstn_q;
    assign dec_in_valid = dec_in_valid_q;
    assign dec_in       = dec_in_q;
    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign m_last       = m_last_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_timeout  = err_q;
`ifdef VITERBI_CTRL_STATS_EN
    assign stat_frames   = stat_frames_q;
    assign stat_timeouts = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl with a 1-bit-per-pair decoder stub and a throttleable source.
module tb_viterbi_frame_ctrl;

    localparam int FL        = 512;
    localparam int TBL       = 32;
    localparam int TO        = 4095;
    localparam int SRC_TOTAL = 600;

    logic       clk;
    logic       RST;
    logic       start;
    logic       s_valid;
    logic       s_ready;
    logic [1:0] s_data;
    logic       dec_RSTn;
    logic       dec_in_valid;
    logic [1:0] dec_in;
    logic       dec_out_valid;
    logic       dec_out;
    logic       m_valid;
    logic       m_data;
    logic       m_last;
    logic       busy;
    logic       done;
    logic       err_timeout;

    viterbi_frame_ctrl #(
        .FRAME_LEN (FL),
        .TBLEN     (TBL),
        .CLR_CYC   (2),
        .TIMEOUT   (TO)
    ) dut (
        .clk           (clk),
        .RST           (RST),
        .start         (start),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .dec_RSTn      (dec_RSTn),
        .dec_in_valid  (dec_in_valid),
        .dec_in        (dec_in),
        .dec_out_valid (dec_out_valid),
        .dec_out       (dec_out),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_last        (m_last),
        .busy          (busy),
        .done          (done),
        .err_timeout   (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Knobs written only by the test tasks
    logic tb_clr     = 1'b0;
    logic src_en     = 1'b0;
    logic src_full   = 1'b1;
    int   stub_limit = 0;
    logic err_after_start;

    // State written only by the monitor/stub/source process
    logic [1:0] din_arr [0:1023];
    logic       m_arr   [0:1023];
    int din_n, m_n, last_n, last_idx, done_n, stub_n, acc_n, ready_viol;
    int cyc, last_din_cyc, to_cyc;
    logic to_seen, acc_pend;

    function automatic logic [1:0] pat(input int i);
        int v;
        v = (i * 37) ^ (i >> 3);
        return v[1:0];
    endfunction

    function automatic int m_errs(input int n);
        int e = 0;
        for (int k = 0; k < n && k < 1024; k++)
            if (m_arr[k] !== ^pat(k)) e++;
        return e;
    endfunction

    function automatic int payload_errs();
        int e = 0;
        for (int k = 0; k < FL; k++)
            if (din_arr[k] !== pat(k)) e++;
        return e;
    endfunction

    function automatic int flush_errs();
        int e = 0;
        for (int k = FL; k < FL + TBL; k++)
            if (din_arr[k] !== 2'b00) e++;
        return e;
    endfunction

    initial begin
        s_valid = 1'b0; s_data = 2'b00; dec_out_valid = 1'b0; dec_out = 1'b0;
        din_n = 0; m_n = 0; last_n = 0; last_idx = -1; done_n = 0; stub_n = 0;
        acc_n = 0; ready_viol = 0; cyc = 0; last_din_cyc = 0; to_cyc = 0;
        to_seen = 1'b0; acc_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (tb_clr) begin
                din_n = 0; m_n = 0; last_n = 0; last_idx = -1; done_n = 0; stub_n = 0;
                acc_n = 0; ready_viol = 0; last_din_cyc = 0; to_cyc = 0;
                to_seen = 1'b0; acc_pend = 1'b0;
                s_valid = 1'b0; s_data = 2'b00; dec_out_valid = 1'b0; dec_out = 1'b0;
            end else begin
                cyc++;
                if (dec_in_valid) begin
                    if (din_n < 1024) din_arr[din_n] = dec_in;
                    din_n++;
                    last_din_cyc = cyc;
                end
                if (m_valid) begin
                    if (m_n < 1024) m_arr[m_n] = m_data;
                    if (m_last) begin last_n++; last_idx = m_n; end
                    m_n++;
                end
                if (done) done_n++;
                if (err_timeout && !to_seen) begin to_seen = 1'b1; to_cyc = cyc; end
                // decoder stub: one parity bit per pair, half a cycle later
                if (dec_RSTn && dec_in_valid && stub_n < stub_limit) begin
                    dec_out_valid = 1'b1; dec_out = ^dec_in; stub_n++;
                end else begin
                    dec_out_valid = 1'b0; dec_out = 1'b0;
                end
                if (acc_pend) acc_n++;
                if (s_ready && acc_n >= FL) ready_viol++;
                if (src_en && acc_n < SRC_TOTAL && (src_full || $urandom_range(0, 1) == 1)) begin
                    s_valid = 1'b1; s_data = pat(acc_n);
                end else begin
                    s_valid = 1'b0; s_data = 2'b00;
                end
                acc_pend = s_valid && s_ready;
            end
        end
    end

    task automatic run_frame(input logic full, input int limit, input int bound,
                             input logic poke, output logic ok);
        src_en = 1'b0; tb_clr = 1'b1;
        @(negedge clk); @(negedge clk);
        tb_clr = 1'b0; src_full = full; stub_limit = limit;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        err_after_start = err_timeout;
        src_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            start = poke && (i == 200);
            @(negedge clk);
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic reached;
        repeat (3) @(negedge clk);
        n_chk++; if (dec_RSTn !== 1'b0) $display("FAIL rst_dec_RSTn got %b want 0", dec_RSTn); else n_pass++;
        n_chk++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready got %b want 0", s_ready); else n_pass++;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid got %b want 0", m_valid); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
        n_chk++; if (err_timeout !== 1'b0) $display("FAIL rst_err got %b want 0", err_timeout); else n_pass++;
        n_chk++; if (dec_in_valid !== 1'b0) $display("FAIL rst_dec_in_valid got %b want 0", dec_in_valid); else n_pass++;
        RST = 1'b0;
        tb_clr = 1'b1; @(negedge clk); @(negedge clk); tb_clr = 1'b0;
        src_full = 1'b1; stub_limit = 10000;
        start = 1'b1; @(negedge clk); start = 1'b0; src_en = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (acc_n >= 50) begin reached = 1'b1; break; end
        end
        n_chk++; if (reached !== 1'b1) $display("FAIL midfeed_reach got %b want 1", reached); else n_pass++;
        n_chk++; if (m_valid !== 1'b1) $display("FAIL midfeed_m_valid got %b want 1", m_valid); else n_pass++;
        RST = 1'b1;
        #1;
        n_chk++; if (dec_RSTn !== 1'b0) $display("FAIL midrst_dec_RSTn got %b want 0", dec_RSTn); else n_pass++;
        n_chk++; if (s_ready !== 1'b0) $display("FAIL midrst_s_ready got %b want 0", s_ready); else n_pass++;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL midrst_m_valid got %b want 0", m_valid); else n_pass++;
        src_en = 1'b0;
        repeat (3) @(negedge clk);
        RST = 1'b0;
        repeat (4) @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL postrst_busy got %b want 0", busy); else n_pass++;
        n_chk++; if (dec_RSTn !== 1'b0) $display("FAIL postrst_dec_RSTn got %b want 0", dec_RSTn); else n_pass++;
        n_chk++; if (done_n !== 0) $display("FAIL postrst_done got %0d want 0", done_n); else n_pass++;
        n_chk++; if (last_n !== 0) $display("FAIL postrst_m_last got %0d want 0", last_n); else n_pass++;
    endtask

    task automatic test_clear();
        logic ok;
        src_en = 1'b0; tb_clr = 1'b1;
        @(negedge clk); @(negedge clk);
        tb_clr = 1'b0; src_full = 1'b1; stub_limit = 10000;
        start = 1'b1; @(negedge clk); start = 1'b0;
        n_chk++; if (busy !== 1'b1) $display("FAIL clr_busy got %b want 1", busy); else n_pass++;
        n_chk++; if (dec_RSTn !== 1'b0) $display("FAIL clr_c0_rstn got %b want 0", dec_RSTn); else n_pass++;
        n_chk++; if (dec_in_valid !== 1'b0) $display("FAIL clr_c0_div got %b want 0", dec_in_valid); else n_pass++;
        @(negedge clk);
        n_chk++; if (dec_RSTn !== 1'b0) $display("FAIL clr_c1_rstn got %b want 0", dec_RSTn); else n_pass++;
        n_chk++; if (dec_in_valid !== 1'b0) $display("FAIL clr_c1_div got %b want 0", dec_in_valid); else n_pass++;
        @(negedge clk);
        n_chk++; if (dec_RSTn !== 1'b1) $display("FAIL clr_c2_rstn got %b want 1", dec_RSTn); else n_pass++;
        n_chk++; if (s_ready !== 1'b1) $display("FAIL clr_c2_ready got %b want 1", s_ready); else n_pass++;
        src_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
        n_chk++; if (ok !== 1'b1) $display("FAIL clr_frame_done got %b want 1", ok); else n_pass++;
    endtask

    task automatic test_nominal();
        logic ok;
        run_frame(1'b1, 10000, 2000, 1'b0, ok);
        repeat (2) @(negedge clk);
        n_chk++; if (ok !== 1'b1) $display("FAIL nom_done_seen got %b want 1", ok); else n_pass++;
        n_chk++; if (acc_n !== FL) $display("FAIL nom_accepts got %0d want %0d", acc_n, FL); else n_pass++;
        n_chk++; if (din_n !== FL + TBL) $display("FAIL nom_din_count got %0d want %0d", din_n, FL + TBL); else n_pass++;
        n_chk++; if (payload_errs() !== 0) $display("FAIL nom_din_payload got %0d errs want 0", payload_errs()); else n_pass++;
        n_chk++; if (flush_errs() !== 0) $display("FAIL nom_din_flush got %0d errs want 0", flush_errs()); else n_pass++;
        n_chk++; if (m_n !== FL) $display("FAIL nom_m_count got %0d want %0d", m_n, FL); else n_pass++;
        n_chk++; if (m_errs(FL) !== 0) $display("FAIL nom_m_data got %0d errs want 0", m_errs(FL)); else n_pass++;
        n_chk++; if (last_n !== 1) $display("FAIL nom_last_count got %0d want 1", last_n); else n_pass++;
        n_chk++; if (last_idx !== FL - 1) $display("FAIL nom_last_idx got %0d want %0d", last_idx, FL - 1); else n_pass++;
        n_chk++; if (done_n !== 1) $display("FAIL nom_done_pulses got %0d want 1", done_n); else n_pass++;
        n_chk++; if (err_timeout !== 1'b0) $display("FAIL nom_err got %b want 0", err_timeout); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL nom_busy_after got %b want 0", busy); else n_pass++;
        n_chk++; if (ready_viol !== 0) $display("FAIL nom_ready_after_last got %0d want 0", ready_viol); else n_pass++;
    endtask

    task automatic test_throttled();
        logic ok;
        run_frame(1'b0, 10000, 4000, 1'b0, ok);
        repeat (2) @(negedge clk);
        n_chk++; if (ok !== 1'b1) $display("FAIL thr_done_seen got %b want 1", ok); else n_pass++;
        n_chk++; if (acc_n !== FL) $display("FAIL thr_accepts got %0d want %0d", acc_n, FL); else n_pass++;
        n_chk++; if (din_n !== FL + TBL) $display("FAIL thr_din_count got %0d want %0d", din_n, FL + TBL); else n_pass++;
        n_chk++; if (payload_errs() !== 0) $display("FAIL thr_din_order got %0d errs want 0", payload_errs()); else n_pass++;
        n_chk++; if (ready_viol !== 0) $display("FAIL thr_ready_after_last got %0d want 0", ready_viol); else n_pass++;
        n_chk++; if (m_n !== FL) $display("FAIL thr_m_count got %0d want %0d", m_n, FL); else n_pass++;
        n_chk++; if (last_idx !== FL - 1) $display("FAIL thr_last_idx got %0d want %0d", last_idx, FL - 1); else n_pass++;
    endtask

    task automatic test_timeout();
        logic ok;
        run_frame(1'b1, 100, 6000, 1'b0, ok);
        repeat (2) @(negedge clk);
        n_chk++; if (ok !== 1'b1) $display("FAIL to_done_seen got %b want 1", ok); else n_pass++;
        n_chk++; if (err_timeout !== 1'b1) $display("FAIL to_err got %b want 1", err_timeout); else n_pass++;
        n_chk++; if (to_cyc - last_din_cyc !== TO) $display("FAIL to_delay got %0d want %0d", to_cyc - last_din_cyc, TO); else n_pass++;
        n_chk++; if (m_n !== 100) $display("FAIL to_m_count got %0d want 100", m_n); else n_pass++;
        n_chk++; if (last_n !== 0) $display("FAIL to_no_last got %0d want 0", last_n); else n_pass++;
        n_chk++; if (done_n !== 1) $display("FAIL to_done_pulses got %0d want 1", done_n); else n_pass++;
        run_frame(1'b1, 10000, 2000, 1'b0, ok);
        repeat (2) @(negedge clk);
        n_chk++; if (err_after_start !== 1'b0) $display("FAIL to_err_cleared got %b want 0", err_after_start); else n_pass++;
        n_chk++; if (ok !== 1'b1) $display("FAIL to_next_done got %b want 1", ok); else n_pass++;
        n_chk++; if (last_n !== 1) $display("FAIL to_next_last got %0d want 1", last_n); else n_pass++;
    endtask

    task automatic test_excess();
        logic ok;
        run_frame(1'b1, 520, 2000, 1'b1, ok);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (ok !== 1'b1) $display("FAIL ex_done_seen got %b want 1", ok); else n_pass++;
        n_chk++; if (stub_n !== 520) $display("FAIL ex_stub_bits got %0d want 520", stub_n); else n_pass++;
        n_chk++; if (m_n !== FL) $display("FAIL ex_m_count got %0d want %0d", m_n, FL); else n_pass++;
        n_chk++; if (m_errs(FL) !== 0) $display("FAIL ex_m_data got %0d errs want 0", m_errs(FL)); else n_pass++;
        n_chk++; if (last_idx !== FL - 1) $display("FAIL ex_last_idx got %0d want %0d", last_idx, FL - 1); else n_pass++;
        n_chk++; if (last_n !== 1) $display("FAIL ex_last_count got %0d want 1", last_n); else n_pass++;
        n_chk++; if (done_n !== 1) $display("FAIL ex_done_pulses got %0d want 1", done_n); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL ex_busy_after got %b want 0", busy); else n_pass++;
        n_chk++; if (acc_n !== FL) $display("FAIL ex_accepts got %0d want %0d", acc_n, FL); else n_pass++;
    endtask

    initial begin
        RST   = 1'b1;
        start = 1'b0;
        test_reset();
        test_clear();
        test_nominal();
        test_throttled();
        test_timeout();
        test_excess();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
